// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch/load-store request ports and veda memory bus of mem_arbiter
interface mem_arbiter_if #(
  parameter int ADDRESS_WIDTH = 6,
  parameter int DATA_SIZE     = 32
);
  logic                     if_req;
  logic [ADDRESS_WIDTH:0]   if_addr;
  logic                     if_ack;
  logic [DATA_SIZE-1:0]     if_rdata;

  logic                     ls_req;
  logic                     ls_we;
  logic [ADDRESS_WIDTH:0]   ls_addr;
  logic [DATA_SIZE-1:0]     ls_wdata;
  logic                     ls_ack;
  logic [DATA_SIZE-1:0]     ls_rdata;

  logic                     mem_write_enable;
  logic [ADDRESS_WIDTH:0]   mem_addr;
  logic [DATA_SIZE-1:0]     mem_datain;
  logic [DATA_SIZE-1:0]     mem_dataout;

  logic                     busy;

  // Requesters and veda side
  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_dataout,
    input  if_ack, if_rdata, ls_ack, ls_rdata,
    input  mem_write_enable, mem_addr, mem_datain, busy
  );

  // Arbiter side
  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_dataout,
    output if_ack, if_rdata, ls_ack, ls_rdata,
    output mem_write_enable, mem_addr, mem_datain, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing single-port veda between fetch and load/store
module mem_arbiter #(
  parameter int ADDRESS_WIDTH = 6,
  parameter int DATA_SIZE     = 32
) (
  input  logic           clk,
  input  logic           rst,
  mem_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_LS = 1'b1;

  state_t                 state_q, state_d;
  logic                   last_grant_q, last_grant_d;
  logic                   grant_q, grant_d;
  logic [ADDRESS_WIDTH:0] cmd_addr_q, cmd_addr_d;
  logic                   cmd_we_q, cmd_we_d;
  logic [DATA_SIZE-1:0]   cmd_wdata_q, cmd_wdata_d;
  logic                   mem_we_q, mem_we_d;
  logic                   if_ack_q, if_ack_d;
  logic                   ls_ack_q, ls_ack_d;
  logic                   sel_valid;
  logic                   sel_ls;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    cmd_addr_d   = cmd_addr_q;
    cmd_we_d     = cmd_we_q;
    cmd_wdata_d  = cmd_wdata_q;
    mem_we_d     = 1'b0;
    if_ack_d     = 1'b0;
    ls_ack_d     = 1'b0;
    sel_valid    = 1'b0;
    sel_ls       = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.if_req || bus.ls_req) begin
          sel_valid = 1'b1;
          sel_ls    = bus.ls_req && (!bus.if_req || (last_grant_q == PORT_IF));
        end
      end
      ACCESS: begin
        state_d  = RESP;
        if_ack_d = (grant_q == PORT_IF);
        ls_ack_d = (grant_q == PORT_LS);
      end
      RESP: begin
        // The just-acked port's req is still high here, so only the other port may chain in.
        state_d = IDLE;
        if (grant_q == PORT_LS && bus.if_req) begin
          sel_valid = 1'b1;
          sel_ls    = 1'b0;
        end else if (grant_q == PORT_IF && bus.ls_req) begin
          sel_valid = 1'b1;
          sel_ls    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (sel_valid) begin
      state_d      = ACCESS;
      grant_d      = sel_ls;
      last_grant_d = sel_ls;
      cmd_addr_d   = sel_ls ? bus.ls_addr : bus.if_addr;
      cmd_we_d     = sel_ls && bus.ls_we;
      cmd_wdata_d  = sel_ls ? bus.ls_wdata : '0;
      mem_we_d     = sel_ls && bus.ls_we;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= PORT_IF;
      grant_q      <= PORT_IF;
      cmd_addr_q   <= '0;
      cmd_we_q     <= 1'b0;
      cmd_wdata_q  <= '0;
      mem_we_q     <= 1'b0;
      if_ack_q     <= 1'b0;
      ls_ack_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_we_q     <= cmd_we_d;
      cmd_wdata_q  <= cmd_wdata_d;
      mem_we_q     <= mem_we_d;
      if_ack_q     <= if_ack_d;
      ls_ack_q     <= ls_ack_d;
    end
  end

  // veda returns read data during RESP, so rdata is gated through rather than registered.
  assign bus.if_rdata         = if_ack_q ? bus.mem_dataout : '0;
  assign bus.ls_rdata         = (ls_ack_q && !cmd_we_q) ? bus.mem_dataout : '0;
  assign bus.if_ack           = if_ack_q;
  assign bus.ls_ack           = ls_ack_q;
  assign bus.mem_write_enable = mem_we_q;
  assign bus.mem_addr         = cmd_addr_q;
  assign bus.mem_datain       = cmd_wdata_q;
  assign bus.busy             = (state_q != IDLE);

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port data memory (veda) between the instruction-fetch path and the CU load/store path.
- Per-port req/ack handshake; round-robin arbitration on conflict.
- One access in flight; memory read latency is one clock.
- Sits between CU/instruction_fetch and veda and drives veda's write_enable/addr/datain.

Parameters:
- ADDRESS_WIDTH, 6, address MSB index; all address buses are [ADDRESS_WIDTH:0] (7 bits).
- DATA_SIZE, 32, width of data buses.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch read request; held until if_ack.
- if_addr  in  ADDRESS_WIDTH+1  fetch address.
- if_ack  out  1  one-cycle pulse: fetch done, if_rdata valid.
- if_rdata  out  DATA_SIZE  fetch read data.
- ls_req  in  1  load/store request; held until ls_ack.
- ls_we  in  1  1 = store, 0 = load.
- ls_addr  in  ADDRESS_WIDTH+1  load/store address.
- ls_wdata  in  DATA_SIZE  store data.
- ls_ack  out  1  one-cycle pulse: access done, ls_rdata valid for loads.
- ls_rdata  out  DATA_SIZE  load data.
- mem_write_enable  out  1  to veda write_enable.
- mem_addr  out  ADDRESS_WIDTH+1  to veda addr.
- mem_datain  out  DATA_SIZE  to veda datain.
- mem_dataout  in  DATA_SIZE  from veda; valid the cycle after the address is presented.
- busy  out  1  high in ACCESS and RESP.

Behaviour:
- Reset values (next posedge with rst=1):
  - state=IDLE, last_grant=IF.
  - All acks, mem_write_enable and busy = 0.
  - mem_addr, mem_datain, if_rdata and ls_rdata = 0.
  - Command registers cleared.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - If any req is high, pick the winner, latch its addr/we/wdata into command registers (IF: we=0) and go to ACCESS.
  - Otherwise stay in IDLE.
- Arbitration:
  - Single requester wins.
  - Both high: grant the port that is not last_grant. last_grant updates on every grant.
  - First conflict after reset goes to LS.
- ACCESS (exactly 1 cycle):
  - mem_addr/mem_datain driven from command registers.
  - mem_write_enable = latched we; it is high only in this state.
  - Next state RESP.
- RESP (exactly 1 cycle):
  - Granted port's ack = 1.
  - rdata = mem_dataout for loads/fetches; ls_rdata = 0 for stores.
  - The non-granted rdata stays 0.
- RESP exit:
  - Arbitrate among reqs excluding the port just acked (its req is assumed to still be high this cycle).
  - If the other port requests, latch it and go to ACCESS.
  - Otherwise go to IDLE.
- Latency and throughput:
  - Latency from req sampled in IDLE to ack = 2 cycles.
  - Sustained throughput = 1 access per 2 cycles under alternating demand.
  - A single port re-requesting back-to-back gets 1 access per 3 cycles (passes through IDLE).
- Outside RESP, acks are 0 and rdata outputs are 0.
- Request changes:
  - Input changes after latching have no effect on the in-flight access.
  - Dropping req after grant does not cancel it; the ack still fires.
- Reset mid-operation: the access is abandoned with no ack. If rst is sampled during ACCESS, the write has already been presented to veda that cycle and completes; the arbiter does not undo it.
- Address arithmetic: no wrap or offset; addresses pass through unmodified.

Test Plan:
- Reset, then ls_req=1, ls_we=1, ls_addr=5, ls_wdata=0xDEADBEEF.
  - mem_write_enable=1 with mem_addr=5 in cycle 1 only; ls_ack in cycle 2; ls_rdata=0.
- Reset, then if_req=1, if_addr=5.
  - ls_req held low throughout.
  - mem_addr=5, write_enable=0 in cycle 1; if_ack in cycle 2 with if_rdata=0xDEADBEEF.
- Reset, then if_req and ls_req both high continuously (ls load addr 3, if addr 7).
  - Grants go LS, IF, LS, IF; acks land in cycles 2, 4, 6, 8.
  - mem_addr sequence 3, 7, 3, 7.
- Single port held high for 4 accesses: acks every 3 cycles, with an IDLE cycle between each.
- ls_req raised then dropped one cycle after grant: ls_ack still pulses exactly once; no second access is started.
- rst asserted while state=RESP pending → no ack, busy=0 next cycle, and the next req is served normally with last_grant=IF.
